lab4_cpu_oci_dct_packer: RTL and testbench



---
 rtl/lab4_cpu_oci_dct_packer_pkg.sv | 11 +
 rtl/lab4_cpu_oci_dct_accum.sv | 76 +++++++
 rtl/lab4_cpu_oci_dct_packer.sv | 74 +++++++
 tb/tb_lab4_cpu_oci_dct_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lab4_cpu_oci_dct_packer_pkg.sv
// Shared sizes and state encodings for the OCI debug-trace packer.
// Optional drop counter on the top level is enabled with DCT_PACKER_DROP_CNT_EN.
package lab4_cpu_oci_dct_packer_pkg;
    localparam int SYM_W = 2;
    localparam int SLOTS = 15;
    localparam int CNT_W = 4;
    localparam int BUF_W = SYM_W * SLOTS;

    typedef enum logic [1:0] {ACC_EMPTY, ACC_FILLING, ACC_FULL} acc_state_t;
    typedef enum logic {OUT_IDLE, OUT_VALID} out_state_t;
endpackage

// File: rtl/lab4_cpu_oci_dct_accum.sv
// Trace-symbol accumulator: LSB-first slot writes, symbol count, flush marking
// and the idle timer that auto-flushes a partial word.
module lab4_cpu_oci_dct_accum
    import lab4_cpu_oci_dct_packer_pkg::*;
#(
    parameter int IDLE_FLUSH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             flush,
    input  logic             out_free,
    output logic             sym_ready,
    output logic             handoff,
    output logic [BUF_W-1:0] acc_word,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             acc_flushed
);
    acc_state_t       state, state_next;
    logic [15:0]      idle_cnt, idle_next;
    logic [BUF_W-1:0] word_base, word_next;
    logic [CNT_W-1:0] cnt_base, cnt_next;
    logic             xfer, auto_flush, mark_full, flushed_next;

    assign handoff   = (state == ACC_FULL) && out_free;
    assign sym_ready = !((state == ACC_FULL) && !out_free);
    assign xfer      = sym_valid && sym_ready;

    always_comb begin
        // On a hand-off edge the new symbol lands in a fresh, empty accumulator
        word_base = handoff ? '0 : acc_word;
        cnt_base  = handoff ? '0 : acc_cnt;
        word_next = word_base;
        cnt_next  = cnt_base;
        if (xfer) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (cnt_base == CNT_W'(i)) word_next[i*SYM_W +: SYM_W] = sym_data;
            end
            cnt_next = cnt_base + CNT_W'(1);
        end
        auto_flush   = (IDLE_FLUSH != 0) && (state == ACC_FILLING) && !xfer && !flush
                       && ((idle_cnt + 16'd1) == 16'(IDLE_FLUSH));
        mark_full    = (cnt_next == CNT_W'(SLOTS)) || ((flush || auto_flush) && (cnt_next != '0));
        flushed_next = flush && (cnt_next != '0);
        if (mark_full)              state_next = ACC_FULL;
        else if (cnt_next == '0)    state_next = ACC_EMPTY;
        else                        state_next = ACC_FILLING;
        if (xfer || flush || mark_full || (state != ACC_FILLING)) idle_next = '0;
        else                                                      idle_next = idle_cnt + 16'd1;
        // A finished word waiting on a busy output register is frozen
        if ((state == ACC_FULL) && !handoff) begin
            word_next    = acc_word;
            cnt_next     = acc_cnt;
            state_next   = ACC_FULL;
            flushed_next = acc_flushed;
            idle_next    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACC_EMPTY;
            acc_word    <= '0;
            acc_cnt     <= '0;
            acc_flushed <= 1'b0;
            idle_cnt    <= '0;
        end else begin
            state       <= state_next;
            acc_word    <= word_next;
            acc_cnt     <= cnt_next;
            acc_flushed <= flushed_next;
            idle_cnt    <= idle_next;
        end
    end
endmodule

// File: rtl/lab4_cpu_oci_dct_packer.sv
// Double-buffered OCI trace packer: accumulator plus valid/ready output register.
// Define DCT_PACKER_DROP_CNT_EN to add the saturating drop_count output.
module lab4_cpu_oci_dct_packer
    import lab4_cpu_oci_dct_packer_pkg::*;
#(
    parameter int IDLE_FLUSH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    input  logic             flush,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             dct_valid,
    input  logic             dct_ready,
`ifdef DCT_PACKER_DROP_CNT_EN
    output logic [15:0]      drop_count,
`endif
    output logic             test_ending
);
    out_state_t       out_state;
    logic             out_free, handoff, acc_flushed;
    logic [BUF_W-1:0] acc_word;
    logic [CNT_W-1:0] acc_cnt;

    assign out_free  = (out_state == OUT_IDLE) || dct_ready;
    assign dct_valid = (out_state == OUT_VALID);

    lab4_cpu_oci_dct_accum #(
        .IDLE_FLUSH (IDLE_FLUSH)
    ) u_accum (
        .clk         (clk),
        .reset_n     (reset_n),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .flush       (flush),
        .out_free    (out_free),
        .sym_ready   (sym_ready),
        .handoff     (handoff),
        .acc_word    (acc_word),
        .acc_cnt     (acc_cnt),
        .acc_flushed (acc_flushed)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_state   <= OUT_IDLE;
            dct_buffer  <= '0;
            dct_count   <= '0;
            test_ending <= 1'b0;
        end else begin
            test_ending <= 1'b0;
            if (handoff) begin
                out_state   <= OUT_VALID;
                dct_buffer  <= acc_word;
                dct_count   <= acc_cnt;
                test_ending <= acc_flushed;
            end else if (dct_ready) begin
                out_state   <= OUT_IDLE;
            end
        end
    end

`ifdef DCT_PACKER_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                       drop_count <= '0;
        else if (flush)                                     drop_count <= '0;
        else if (sym_valid && !sym_ready && (drop_count != 16'hFFFF))
                                                            drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_lab4_cpu_oci_dct_packer.sv
// Directed bench for the OCI trace packer; covers DCT_PACKER_DROP_CNT_EN when defined.
module tb_lab4_cpu_oci_dct_packer;
    import lab4_cpu_oci_dct_packer_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sym_valid = 1'b0;
    logic [SYM_W-1:0] sym_data = '0;
    logic             flush = 1'b0;
    logic             dct_ready = 1'b1;
    logic             sym_ready, dct_valid, test_ending;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
`ifdef DCT_PACKER_DROP_CNT_EN
    logic [15:0]      drop_count;
`endif
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lab4_cpu_oci_dct_packer #(
        .IDLE_FLUSH (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_ready   (sym_ready),
        .flush       (flush),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .dct_valid   (dct_valid),
        .dct_ready   (dct_ready),
`ifdef DCT_PACKER_DROP_CNT_EN
        .drop_count  (drop_count),
`endif
        .test_ending (test_ending)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(dct_valid), 32'd0);
        chk("rst_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_count", 32'(dct_count), 32'd0);
        chk("rst_ending", 32'(test_ending), 32'd0);
        chk("rst_ready", 32'(sym_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // Full word of 0,1,2,3,... with the sink always ready
        for (int i = 0; i < 15; i++) begin
            sym_valid = 1'b1;
            sym_data  = SYM_W'(i % 4);
            tick();
        end
        sym_valid = 1'b0;
        chk("full_latency", 32'(dct_valid), 32'd0);
        tick();
        chk("full_valid", 32'(dct_valid), 32'd1);
        chk("full_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        chk("full_count", 32'(dct_count), 32'd15);
        chk("full_no_ending", 32'(test_ending), 32'd0);
        tick();
        chk("full_taken", 32'(dct_valid), 32'd0);

        // Partial word 3,2,1 closed by an explicit flush
        sym_valid = 1'b1;
        sym_data = 2'd3; tick();
        sym_data = 2'd2; tick();
        sym_data = 2'd1; tick();
        sym_valid = 1'b0;
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("flush_latency", 32'(dct_valid), 32'd0);
        tick();
        chk("flush_valid", 32'(dct_valid), 32'd1);
        chk("flush_buffer", 32'(dct_buffer), 32'h1B);
        chk("flush_count", 32'(dct_count), 32'd3);
        chk("flush_ending", 32'(test_ending), 32'd1);
        tick();
        chk("flush_ending_pulse", 32'(test_ending), 32'd0);
        chk("flush_taken", 32'(dct_valid), 32'd0);

        // Back-pressure: 15 x sym 1, 15 x sym 2, then sym 3 stalls
        dct_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sym_valid = 1'b1;
            sym_data  = (i < 15) ? 2'd1 : 2'd2;
            tick();
        end
        sym_data = 2'd3;
        #1;
        chk("bp_stall_ready", 32'(sym_ready), 32'd0);
        chk("bp_word1_valid", 32'(dct_valid), 32'd1);
        chk("bp_word1_buffer", 32'(dct_buffer), 32'h15555555);
        tick();
        tick();
        chk("bp_word1_stable", 32'(dct_buffer), 32'h15555555);
        chk("bp_word1_count", 32'(dct_count), 32'd15);
        chk("bp_still_stalled", 32'(sym_ready), 32'd0);
        dct_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(sym_ready), 32'd1);
        tick();
        sym_valid = 1'b0;
        chk("bp_word2_valid", 32'(dct_valid), 32'd1);
        chk("bp_word2_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("bp_word2_count", 32'(dct_count), 32'd15);
        flush = 1'b1; tick();
        flush = 1'b0;
        tick();
        chk("bp_word3_valid", 32'(dct_valid), 32'd1);
        chk("bp_word3_buffer", 32'(dct_buffer), 32'h3);
        chk("bp_word3_count", 32'(dct_count), 32'd1);
        tick();

        // Auto-flush after 16 idle cycles
        sym_valid = 1'b1;
        sym_data = 2'd2; tick();
        sym_data = 2'd1; tick();
        sym_valid = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("auto_latency", 32'(dct_valid), 32'd0);
        tick();
        chk("auto_valid", 32'(dct_valid), 32'd1);
        chk("auto_buffer", 32'(dct_buffer), 32'h6);
        chk("auto_count", 32'(dct_count), 32'd2);
        chk("auto_no_ending", 32'(test_ending), 32'd0);
        tick();

        // Flush with nothing held emits nothing
        flush = 1'b1; tick();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("empty_flush_quiet", 32'(dct_valid), 32'd0);
        end

        // Mid-operation reset discards 7 held symbols
        for (int i = 0; i < 7; i++) begin
            sym_valid = 1'b1;
            sym_data  = SYM_W'(3 - (i % 4));
            tick();
        end
        sym_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dct_valid), 32'd0);
        chk("mid_rst_buffer", 32'(dct_buffer), 32'd0);
        chk("mid_rst_count", 32'(dct_count), 32'd0);
        chk("mid_rst_ready", 32'(sym_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("post_rst_quiet", 32'(dct_valid), 32'd0);
        end

`ifdef DCT_PACKER_DROP_CNT_EN
        // Stalled symbols are counted, and a flush clears the count
        dct_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sym_valid = 1'b1;
            sym_data  = SYM_W'(i % 4);
            tick();
        end
        chk("drop_none_yet", 32'(drop_count), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("drop_count5", 32'(drop_count), 32'd5);
        flush = 1'b1; tick();
        flush = 1'b0;
        chk("drop_cleared", 32'(drop_count), 32'd0);
        sym_valid = 1'b0;
        dct_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
